// File: rtl/lsu_dmem_if.sv
// Request/response bus between the ALU-side requester and the lsu_dmem load/store unit.
interface lsu_dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [63:0] rdata;

  modport master (
    output req_valid, opcode, func3, addr, wdata,
    input  req_ready, rsp_valid, rsp_err, rdata
  );

  modport slave (
    input  req_valid, opcode, func3, addr, wdata,
    output req_ready, rsp_valid, rsp_err, rdata
  );
endinterface

// File: rtl/lsu_dmem.sv
// RV64 doubleword load/store unit with private memory and fixed wait-state latency.
// Define LSU_BOUNDS_CHECK_EN to reject addresses beyond DEPTH*8 instead of aliasing them.
module lsu_dmem #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  lsu_dmem_if.slave  bus
);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [2:0]  F3_DWORD = 3'b011;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               store_q, store_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [63:0]        wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [63:0]        rdata_q, rdata_d;
  logic [63:0]        mem_q [DEPTH];
  logic [63:0]        mem_d [DEPTH];

  logic               unsupported;
  logic               misaligned;
  logic               out_of_range;

  always_comb begin
    unsupported = !(bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ||
                  (bus.func3 != F3_DWORD);
    misaligned  = (bus.addr[2:0] != 3'b000);
`ifdef LSU_BOUNDS_CHECK_EN
    // DEPTH is a power of two, so any set bit above the index field is out of range.
    out_of_range = ((bus.addr >> (IDX_W + 3)) != 64'd0);
`else
    out_of_range = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    mem_d       = mem_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 4'(LATENCY - 1);
          store_d = (bus.opcode == OP_STORE);
          err_d   = unsupported | misaligned | out_of_range;
          idx_d   = bus.addr[3 +: IDX_W];
          wdata_d = bus.wdata;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!err_q) begin
            if (store_q) mem_d[idx_q] = wdata_q;
            else         rdata_d      = mem_q[idx_q];
          end
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_lsu_dmem.sv
// Self-checking bench for lsu_dmem: reference model plus directed transactions.
module tb_lsu_dmem;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned LATENCY = 2;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  lsu_dmem_if bus ();

  lsu_dmem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a request occupies the unit until LATENCY edges after acceptance.
  logic [63:0] m_mem [DEPTH];
  logic        m_busy;
  logic [63:0] m_edge, m_due;
  logic        m_p_store, m_p_err;
  int unsigned m_p_idx;
  logic [63:0] m_p_wdata;
  logic        m_rsp_v, m_rsp_err;
  logic [63:0] m_rdata;

  function automatic logic classify_err(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [63:0] a);
    logic e;
    e = ((op != OP_LD) && (op != OP_SD)) || (f3 != 3'd3) || ((a % 64'd8) != 64'd0);
`ifdef LSU_BOUNDS_CHECK_EN
    e = e || (a >= 64'(DEPTH) * 64'd8);
`endif
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_edge    <= '0;
      m_due     <= '0;
      m_rsp_v   <= 1'b0;
      m_rsp_err <= 1'b0;
      m_rdata   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] <= '0;
    end else begin
      m_edge    <= m_edge + 64'd1;
      m_rsp_v   <= 1'b0;
      m_rsp_err <= 1'b0;
      if (m_busy && (m_edge == m_due)) begin
        m_rsp_v   <= 1'b1;
        m_rsp_err <= m_p_err;
        if (!m_p_err) begin
          if (m_p_store) m_mem[m_p_idx] <= m_p_wdata;
          else           m_rdata        <= m_mem[m_p_idx];
        end
        m_busy <= 1'b0;
      end
      if (!m_busy && bus.req_valid) begin
        m_busy    <= 1'b1;
        m_due     <= m_edge + 64'(LATENCY);
        m_p_store <= (bus.opcode == OP_SD);
        m_p_err   <= classify_err(bus.opcode, bus.func3, bus.addr);
        m_p_idx   <= int'((bus.addr / 64'd8) % 64'(DEPTH));
        m_p_wdata <= bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 64'(bus.req_ready), 64'(!m_busy));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_v));
      if (m_rsp_v) chk("rsp_err", 64'(bus.rsp_err), 64'(m_rsp_err));
      chk("rdata", bus.rdata, m_rdata);
    end
  end

  logic        last_err;
  logic [63:0] last_data;
  int          last_lat;
  int          last_low;

  // Called at a negedge; accepts on the next posedge once the unit is ready.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 64'(bus.req_ready), 64'd1);
      return;
    end
    bus.opcode    = op;
    bus.func3     = f3;
    bus.addr      = a;
    bus.wdata     = d;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int  n = 0;
    logic found = 1'b0;
    last_low = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (!bus.req_ready) last_low++;
      if (bus.rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("rsp_timeout", 64'(found), 64'd1);
    last_lat  = n;
    last_err  = bus.rsp_err;
    last_data = bus.rdata;
  endtask

  task automatic xact(input logic [6:0] op, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] d);
    issue(op, f3, a, d);
    wait_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.opcode    = '0;
    bus.func3     = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    chk("rst_rdata",     bus.rdata,          64'd0);

    xact(OP_LD, 3'b011, 64'h0, 64'h0);
    chk("ld0_err",  64'(last_err), 64'd0);
    chk("ld0_data", last_data,     64'd0);

    xact(OP_SD, 3'b011, 64'h10, 64'hDEADBEEF_CAFEF00D);
    chk("sd10_err",   64'(last_err), 64'd0);
    chk("sd10_lat",   64'(last_lat), 64'(LATENCY + 1));
    chk("sd10_busy",  64'(last_low), 64'(LATENCY));
    xact(OP_LD, 3'b011, 64'h10, 64'h0);
    chk("ld10_lat",   64'(last_lat), 64'(LATENCY + 1));
    chk("ld10_busy",  64'(last_low), 64'(LATENCY));
    chk("ld10_err",   64'(last_err), 64'd0);
    chk("ld10_data",  last_data,     64'hDEADBEEF_CAFEF00D);

    xact(OP_LD, 3'b011, 64'h0C, 64'h0);
    chk("misalign_err",  64'(last_err), 64'd1);
    chk("misalign_lat",  64'(last_lat), 64'(LATENCY + 1));
    chk("misalign_hold", last_data,     64'hDEADBEEF_CAFEF00D);

    xact(OP_SD, 3'b010, 64'h18, 64'h55);
    chk("f3_err", 64'(last_err), 64'd1);
    xact(OP_LD, 3'b011, 64'h18, 64'h0);
    chk("ld18_err",  64'(last_err), 64'd0);
    chk("ld18_data", last_data,     64'd0);

    xact(OP_ALU, 3'b011, 64'h0, 64'h0);
    chk("opcode_err", 64'(last_err), 64'd1);

    xact(OP_SD, 3'b011, 64'hF8, 64'hA5A5_0000_0000_5A5A);
    xact(OP_LD, 3'b011, 64'hF8, 64'h0);
    chk("top_word_err",  64'(last_err), 64'd0);
    chk("top_word_data", last_data,     64'hA5A5_0000_0000_5A5A);

    xact(OP_SD, 3'b011, 64'h100, 64'h1234);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("oob_err", 64'(last_err), 64'd1);
    xact(OP_LD, 3'b011, 64'h0, 64'h0);
    chk("alias_data", last_data, 64'd0);
`else
    chk("oob_err", 64'(last_err), 64'd0);
    xact(OP_LD, 3'b011, 64'h0, 64'h0);
    chk("alias_data", last_data, 64'h1234);
`endif

    // Reset while the store is waiting must drop it entirely.
    issue(OP_SD, 3'b011, 64'h8, 64'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.rsp_valid) seen++;
      end
      chk("rst_abort_rsp", 64'(seen), 64'd0);
    end
    xact(OP_LD, 3'b011, 64'h8, 64'h0);
    chk("rst_abort_data", last_data, 64'd0);

    // Second request raised one cycle after the first is accepted and held.
    begin
      int   rsps = 0;
      int   n1 = 0, n2 = 0;
      logic e1 = 1'b1, e2 = 1'b1;
      logic [63:0] d2 = '0;
      logic dropped = 1'b0;
      issue(OP_SD, 3'b011, 64'h20, 64'hAAAA);
      bus.opcode    = OP_LD;
      bus.func3     = 3'b011;
      bus.addr      = 64'h20;
      bus.wdata     = 64'h0;
      bus.req_valid = 1'b1;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (bus.rsp_valid) begin
          rsps++;
          if (rsps == 1) begin
            n1 = n;
            e1 = bus.rsp_err;
          end else begin
            n2 = n;
            e2 = bus.rsp_err;
            d2 = bus.rdata;
          end
        end
        if (bus.req_ready && bus.req_valid && !dropped) begin
          @(posedge clk);
          #1 bus.req_valid = 1'b0;
          dropped = 1'b1;
        end
      end
      bus.req_valid = 1'b0;
      chk("ovl_rsp_count", 64'(rsps),    64'd2);
      chk("ovl_first_lat", 64'(n1),      64'(LATENCY + 1));
      chk("ovl_gap",       64'(n2 - n1), 64'(LATENCY + 1));
      chk("ovl_err1",      64'(e1),      64'd0);
      chk("ovl_err2",      64'(e2),      64'd0);
      chk("ovl_data",      d2,           64'hAAAA);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
